// File: rtl/switch_input_reader_pkg.sv
// Shared defaults and helpers for the switch input reader.
// Optional edge-flag outputs are enabled with SWITCH_INPUT_READER_EDGE_FLAGS_EN.
package switch_input_reader_pkg;

    localparam int SW_WIDTH           = 8;
    localparam int SW_SYNC_STAGES     = 2;
    localparam int SW_DEBOUNCE_CYCLES = 1000;

    // Action taken by the event register on a given edge.
    typedef enum logic [1:0] {
        EVT_HOLD  = 2'd0,
        EVT_LOAD  = 2'd1,
        EVT_MERGE = 2'd2,
        EVT_DRAIN = 2'd3
    } evt_op_t;

    // The counter must hold values 0 .. cycles.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_input_reader_if.sv
// Switch bank and change-event handshake between the reader and its consumer.
// Edge-flag signals exist only with SWITCH_INPUT_READER_EDGE_FLAGS_EN defined.
interface switch_input_reader_if
    import switch_input_reader_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic             ena;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_stable;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_data;
    logic             evt_overrun;
`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
    logic [WIDTH-1:0] evt_rise;
    logic [WIDTH-1:0] evt_fall;
`endif

    modport master (
        input  ena,
        input  sw_in,
        input  evt_ready,
        output sw_stable,
        output evt_valid,
        output evt_data,
`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
        output evt_rise,
        output evt_fall,
`endif
        output evt_overrun
    );

    modport slave (
        output ena,
        output sw_in,
        output evt_ready,
        input  sw_stable,
        input  evt_valid,
        input  evt_data,
`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
        input  evt_rise,
        input  evt_fall,
`endif
        input  evt_overrun
    );

endinterface

// File: rtl/switch_input_reader_debounce.sv
// One switch bit: input synchronizer, debounce counter and stable flop.
// 'flip' is high in the cycle whose closing edge toggles 'stable'.
module sw_debounce_bit
    import switch_input_reader_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic stable,
    output logic flip
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sync_bit;
    logic [CW-1:0]          cnt;

    assign sync_bit = sync_p[SYNC_STAGES-1];

    // Synchronizer runs regardless of ena so the level is current when ena returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
        end
    end

    assign flip = ena && (sync_bit != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!ena) begin
            cnt    <= '0;
        end else if (sync_bit == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_bit;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/switch_input_reader.sv
// Switch bank reader: per-bit debounce plus a coalescing change-event register.
// Define SWITCH_INPUT_READER_EDGE_FLAGS_EN to add evt_rise/evt_fall masks.
module switch_input_reader
    import switch_input_reader_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_input_reader_if.master bus
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] next_stable;
    logic             upd;
    evt_op_t          op;

    logic             evt_valid_q;
    logic [WIDTH-1:0] evt_data_q;
    logic             evt_overrun_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .ena   (bus.ena),
            .raw   (bus.sw_in[i]),
            .stable(stable[i]),
            .flip  (flip[i])
        );
    end

    // All bits flipping on one edge become a single event carrying the new value.
    assign next_stable = stable ^ flip;
    assign upd         = |flip;

    always_comb begin
        op = EVT_HOLD;
        if (upd && (!evt_valid_q || bus.evt_ready)) begin
            op = EVT_LOAD;
        end else if (upd) begin
            op = EVT_MERGE;
        end else if (evt_valid_q && bus.evt_ready) begin
            op = EVT_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q   <= 1'b0;
            evt_data_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            case (op)
                EVT_LOAD: begin
                    evt_valid_q   <= 1'b1;
                    evt_data_q    <= next_stable;
                    evt_overrun_q <= 1'b0;
                end
                EVT_MERGE: begin
                    evt_data_q    <= next_stable;
                    evt_overrun_q <= 1'b1;
                end
                EVT_DRAIN: begin
                    evt_valid_q   <= 1'b0;
                    evt_overrun_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_new;
    logic [WIDTH-1:0] fall_new;

    assign rise_new = next_stable & ~stable;
    assign fall_new = ~next_stable & stable;

    // Masks accumulate across coalesced updates so no transition is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            case (op)
                EVT_LOAD: begin
                    rise_q <= rise_new;
                    fall_q <= fall_new;
                end
                EVT_MERGE: begin
                    rise_q <= rise_q | rise_new;
                    fall_q <= fall_q | fall_new;
                end
                EVT_DRAIN: begin
                    rise_q <= '0;
                    fall_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.evt_rise = rise_q;
    assign bus.evt_fall = fall_q;
`endif

    assign bus.sw_stable   = stable;
    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_data    = evt_data_q;
    assign bus.evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_switch_input_reader.sv
// Bench for switch_input_reader: directed scenarios plus randomized traffic
// compared each cycle against a window-based behavioural model.
module tb_switch_input_reader;

    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int HIST  = 64;

    logic clk;
    logic rst;

    switch_input_reader_if #(.WIDTH(W)) bus ();

    switch_input_reader #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Model state
    logic [W-1:0] samp [HIST];
    logic         enh  [HIST];
    int           n;
    logic [W-1:0] st_m;
    logic         vld_m;
    logic [W-1:0] dat_m;
    logic         ovr_m;
    logic [W-1:0] rise_m;
    logic [W-1:0] fall_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        n      = 0;
        st_m   = '0;
        vld_m  = 1'b0;
        dat_m  = '0;
        ovr_m  = 1'b0;
        rise_m = '0;
        fall_m = '0;
    endtask

    // A bit flips once the last DEB synchronized samples (each sw_in delayed by
    // SYNC edges) all disagree with it and ena was high on each of those edges.
    task automatic model_edge();
        logic [W-1:0] nst;
        logic         ok;
        logic         s;
        int           m;
        samp[n % HIST] = bus.sw_in;
        enh[n % HIST]  = bus.ena;
        nst = st_m;
        for (int b = 0; b < W; b++) begin
            ok = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                m = n - k;
                if (m < 0) begin
                    ok = 1'b0;
                end else begin
                    s = (m >= SYNC) ? samp[(m - SYNC) % HIST][b] : 1'b0;
                    if (!enh[m % HIST] || s == st_m[b]) ok = 1'b0;
                end
            end
            if (ok) nst[b] = ~st_m[b];
        end
        if (nst != st_m) begin
            if (!vld_m || bus.evt_ready) begin
                vld_m  = 1'b1;
                dat_m  = nst;
                ovr_m  = 1'b0;
                rise_m = nst & ~st_m;
                fall_m = ~nst & st_m;
            end else begin
                dat_m  = nst;
                ovr_m  = 1'b1;
                rise_m = rise_m | (nst & ~st_m);
                fall_m = fall_m | (~nst & st_m);
            end
        end else if (vld_m && bus.evt_ready) begin
            vld_m  = 1'b0;
            ovr_m  = 1'b0;
            rise_m = '0;
            fall_m = '0;
        end
        st_m = nst;
        n++;
    endtask

    task automatic cmp_all();
        chk("sw_stable", 32'(bus.sw_stable), 32'(st_m));
        chk("evt_valid", 32'(bus.evt_valid), 32'(vld_m));
        chk("evt_data", 32'(bus.evt_data), 32'(dat_m));
        chk("evt_overrun", 32'(bus.evt_overrun), 32'(ovr_m));
`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
        chk("evt_rise", 32'(bus.evt_rise), 32'(rise_m));
        chk("evt_fall", 32'(bus.evt_fall), 32'(fall_m));
`endif
    endtask

    // One clock edge; inputs are changed by callers 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    // Asserts reset between edges and confirms outputs clear with no clock.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_sw_stable", 32'(bus.sw_stable), 32'h0);
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'h0);
        chk("rst_evt_data", 32'(bus.evt_data), 32'h0);
        chk("rst_evt_overrun", 32'(bus.evt_overrun), 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [W-1:0] sw;

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.sw_in     = '0;
        bus.evt_ready = 1'b0;
        model_clear();
        #1;
        do_reset();

        // 1: idle with switches low, no events
        ticks(100);
        chk("t1_stable", 32'(bus.sw_stable), 32'h00);
        chk("t1_valid", 32'(bus.evt_valid), 32'h0);

        // 2: latency is SYNC+DEB edges
        tick();
        bus.sw_in = 8'h05;
        ticks(5);
        chk("t2_stable_early", 32'(bus.sw_stable), 32'h00);
        chk("t2_valid_early", 32'(bus.evt_valid), 32'h0);
        tick();
        chk("t2_stable", 32'(bus.sw_stable), 32'h05);
        chk("t2_valid", 32'(bus.evt_valid), 32'h1);
        chk("t2_data", 32'(bus.evt_data), 32'h05);
        bus.evt_ready = 1'b1;
        tick();
        chk("t2_accept", 32'(bus.evt_valid), 32'h0);
        bus.evt_ready = 1'b0;
        tick();
        do_reset();

        // 3: short glitch rejected, long pulse accepted
        tick();
        bus.sw_in = 8'h08;
        ticks(3);
        bus.sw_in = 8'h00;
        ticks(10);
        chk("t3_glitch_stable", 32'(bus.sw_stable), 32'h00);
        chk("t3_glitch_valid", 32'(bus.evt_valid), 32'h0);
        bus.sw_in = 8'h08;
        ticks(6);
        chk("t3_stable", 32'(bus.sw_stable), 32'h08);
        chk("t3_data", 32'(bus.evt_data), 32'h08);
        do_reset();

        // 4: coalescing while consumer stalls
        tick();
        bus.sw_in = 8'h01;
        ticks(6);
        chk("t4_first", 32'(bus.evt_data), 32'h01);
        bus.sw_in = 8'h03;
        ticks(6);
        chk("t4_data", 32'(bus.evt_data), 32'h03);
        chk("t4_overrun", 32'(bus.evt_overrun), 32'h1);
`ifdef SWITCH_INPUT_READER_EDGE_FLAGS_EN
        chk("t4_rise", 32'(bus.evt_rise), 32'h03);
        chk("t4_fall", 32'(bus.evt_fall), 32'h00);
`endif
        bus.evt_ready = 1'b1;
        tick();
        chk("t4_valid_clr", 32'(bus.evt_valid), 32'h0);
        chk("t4_ovr_clr", 32'(bus.evt_overrun), 32'h0);
        bus.evt_ready = 1'b0;
        do_reset();

        // 5: accept on the same edge as a new update
        tick();
        bus.sw_in = 8'h01;
        ticks(6);
        bus.sw_in = 8'h80;
        ticks(5);
        chk("t5_pre", 32'(bus.sw_stable), 32'h01);
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
        chk("t5_valid", 32'(bus.evt_valid), 32'h1);
        chk("t5_data", 32'(bus.evt_data), 32'h80);
        chk("t5_overrun", 32'(bus.evt_overrun), 32'h0);
        tick();
        do_reset();

        // 6: ena low freezes debounce but keeps the pending event
        tick();
        bus.sw_in = 8'h01;
        ticks(6);
        bus.ena   = 1'b0;
        bus.sw_in = 8'hFF;
        ticks(20);
        chk("t6_hold_stable", 32'(bus.sw_stable), 32'h01);
        chk("t6_pending", 32'(bus.evt_valid), 32'h1);
        bus.ena = 1'b1;
        ticks(3);
        chk("t6_early", 32'(bus.sw_stable), 32'h01);
        tick();
        chk("t6_stable", 32'(bus.sw_stable), 32'hFF);
        chk("t6_overrun", 32'(bus.evt_overrun), 32'h1);
        do_reset();

        // Randomized traffic
        sw = '0;
        for (int it = 0; it < 4000; it++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) sw = sw ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 99) == 0) sw = W'($urandom);
            bus.sw_in     = sw;
            bus.ena       = ($urandom_range(0, 19) != 0);
            bus.evt_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
